// File: rtl/sysid_checker.sv
// Avalon-MM reader for the system ID slave: fetches ID and timestamp,
// compares them to the build values and reports the result.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1409223118,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        error,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE
    } state_t;

    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        error_q, error_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  retry_q, retry_d;

    logic in_req, in_wait, is_ts, capture, expired;

    always_comb begin
        in_req  = (state_q == REQ_ID) || (state_q == REQ_TS);
        in_wait = (state_q == WAIT_ID) || (state_q == WAIT_TS);
        is_ts   = (state_q == REQ_TS) || (state_q == WAIT_TS);
        // data arriving in the acceptance cycle counts as a capture
        capture = (in_req && read_q && !waitrequest && readdatavalid)
               || (in_wait && readdatavalid);
        expired = (in_wait || (in_req && read_q)) && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = done_q;
        id_ok_d = id_ok_q;
        ts_ok_d = ts_ok_q;
        error_d = error_q;
        id_d    = id_q;
        ts_d    = ts_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        if (state_q == IDLE || state_q == DONE) begin
            if (start) begin
                state_d = REQ_ID;
                read_d  = 1'b1;
                addr_d  = 1'b0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                id_ok_d = 1'b0;
                ts_ok_d = 1'b0;
                error_d = 1'b0;
                cnt_d   = '0;
                retry_d = '0;
            end
        end else if (capture) begin
            retry_d = '0;
            cnt_d   = '0;
            if (is_ts) begin
                ts_d    = readdata;
                ts_ok_d = (readdata == EXPECTED_TIMESTAMP);
                read_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end else begin
                id_d    = readdata;
                id_ok_d = (readdata == EXPECTED_ID);
                read_d  = 1'b1;
                addr_d  = 1'b1;
                state_d = REQ_TS;
            end
        end else if (expired) begin
            read_d = 1'b0;
            cnt_d  = '0;
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 3'd1;
                state_d = is_ts ? REQ_TS : REQ_ID;
            end else begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
        end else if (in_req && !read_q) begin
            // first issue after reset, or re-issue after the retry gap
            read_d = 1'b1;
            addr_d = is_ts;
            busy_d = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 16'd1;
            if (in_req && !waitrequest) begin
                read_d  = 1'b0;
                state_d = is_ts ? WAIT_TS : WAIT_ID;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REQ_ID;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_ok_q <= 1'b0;
            ts_ok_q <= 1'b0;
            error_q <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            id_ok_q <= id_ok_d;
            ts_ok_q <= ts_ok_d;
            error_q <= error_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    assign read     = read_q;
    assign address  = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign id_ok    = id_ok_q;
    assign ts_ok    = ts_ok_q;
    assign error    = error_q;
    assign id_value = id_q;
    assign ts_value = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker against a configurable sysid
// slave model (wait states, delayed data, missing data).
module tb_sysid_checker;

    localparam logic [31:0] TS_OK = 32'd1409223118;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        address, read, waitrequest, readdatavalid;
    logic        busy, done, id_ok, ts_ok, error;
    logic [31:0] readdata, id_value, ts_value;

    always #5 clock = ~clock;

    sysid_checker #(
        .TIMEOUT_CYCLES(8),
        .MAX_RETRIES(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .address(address),
        .read(read),
        .waitrequest(waitrequest),
        .readdata(readdata),
        .readdatavalid(readdatavalid),
        .busy(busy),
        .done(done),
        .id_ok(id_ok),
        .ts_ok(ts_ok),
        .error(error),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    logic [31:0] m_id = 32'd0;
    logic [31:0] m_ts = TS_OK;
    int          m_wr_hold = 0;
    int          m_ts_lat = 0;
    logic        m_id_en = 1'b1;
    logic        m_ts_en = 1'b1;
    int          wr_cnt = 0;
    int          pend = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= 0;
            pend   <= 0;
        end else begin
            if (!read) wr_cnt <= 0;
            else if (waitrequest) wr_cnt <= wr_cnt + 1;
            if (read && !waitrequest && address && m_ts_lat > 0)
                pend <= m_ts_lat;
            else if (pend > 0)
                pend <= pend - 1;
        end
    end

    assign waitrequest = read && !address && (wr_cnt < m_wr_hold);
    assign readdatavalid =
        (read && !waitrequest &&
         (address ? (m_ts_en && m_ts_lat == 0) : m_id_en))
        || (pend == 1 && m_ts_en);
    assign readdata = address ? m_ts : m_id;

    int cyc = 0;
    int n_acc0 = 0;
    int n_acc1 = 0;
    int n_rd0 = 0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (read && !waitrequest) begin
            if (address) n_acc1 <= n_acc1 + 1;
            else n_acc0 <= n_acc0 + 1;
        end
        if (read && !address) n_rd0 <= n_rd0 + 1;
    end

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        error;
        logic [31:0] id_value;
        logic [31:0] ts_value;
        int          lat;
        int          acc0;
        int          acc1;
        int          rd0;
        int          t0;
        int          b_acc0;
        int          b_acc1;
        int          b_rd0;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_run(input logic iok, input logic tok,
                            input logic err, input logic [31:0] idv,
                            input logic [31:0] tsv, input int lat,
                            input int a0, input int a1, input int r0);
        exp_t e;
        e.id_ok    = iok;
        e.ts_ok    = tok;
        e.error    = err;
        e.id_value = idv;
        e.ts_value = tsv;
        e.lat      = lat;
        e.acc0     = a0;
        e.acc1     = a1;
        e.rd0      = r0;
        e.t0       = cyc;
        e.b_acc0   = n_acc0;
        e.b_acc1   = n_acc1;
        e.b_rd0    = n_rd0;
        sbq.push_back(e);
    endtask

    task automatic wait_runs(input string name);
        int k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        check({name, "_completed"}, sbq.size(), 0);
        sbq.delete();
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    logic done_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done && !done_prev) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got a run, expected none");
                end else begin
                    e = sbq.pop_front();
                    check("id_ok", {31'd0, id_ok}, {31'd0, e.id_ok});
                    check("ts_ok", {31'd0, ts_ok}, {31'd0, e.ts_ok});
                    check("error", {31'd0, error}, {31'd0, e.error});
                    check("id_value", id_value, e.id_value);
                    check("ts_value", ts_value, e.ts_value);
                    check("latency", cyc - e.t0, e.lat);
                    check("accepts_addr0", n_acc0 - e.b_acc0, e.acc0);
                    check("accepts_addr1", n_acc1 - e.b_acc1, e.acc1);
                    check("read_cycles_addr0", n_rd0 - e.b_rd0, e.rd0);
                end
            end
            done_prev = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1);
    end

    initial begin
        int acc_before;
        repeat (3) @(negedge clock);
        check("reset_flags",
              {25'd0, read, address, busy, done, id_ok, ts_ok, error}, 0);
        check("reset_id_value", id_value, 0);
        check("reset_ts_value", ts_value, 0);

        push_run(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, 3, 1, 1, 1);
        reset_n = 1'b1;
        wait_runs("auto_run");

        m_ts = TS_OK + 32'd1;
        push_run(1'b1, 1'b0, 1'b0, 32'd0, TS_OK + 32'd1, 3, 1, 1, 1);
        pulse_start();
        wait_runs("ts_mismatch");

        m_ts = TS_OK;
        m_wr_hold = 3;
        m_ts_lat = 2;
        push_run(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, 8, 1, 1, 4);
        pulse_start();
        wait_runs("stalls");

        m_wr_hold = 0;
        m_ts_lat = 0;
        m_id_en = 1'b0;
        push_run(1'b0, 1'b0, 1'b1, 32'd0, TS_OK, 27, 3, 0, 3);
        pulse_start();
        wait_runs("timeout");

        m_id_en = 1'b1;
        m_id = 32'd1;
        acc_before = n_acc0 + n_acc1;
        push_run(1'b0, 1'b1, 1'b0, 32'd1, TS_OK, 3, 1, 1, 1);
        pulse_start();
        @(negedge clock);
        pulse_start();
        wait_runs("restart_id1");
        repeat (6) @(negedge clock);
        check("busy_start_ignored", n_acc0 + n_acc1 - acc_before, 2);
        check("done_held", {31'd0, done}, 1);

        m_id = 32'h5;
        m_ts_en = 1'b0;
        pulse_start();
        repeat (4) @(negedge clock);
        check("in_wait_ts", {30'd0, busy, read}, 32'd2);
        check("id_before_reset", id_value, 32'h5);
        reset_n = 1'b0;
        #1;
        check("midrun_reset_flags",
              {25'd0, read, address, busy, done, id_ok, ts_ok, error}, 0);
        check("midrun_reset_values", id_value | ts_value, 0);
        @(negedge clock);
        m_ts_en = 1'b1;
        m_id = 32'd0;
        push_run(1'b1, 1'b1, 1'b0, 32'd0, TS_OK, 3, 1, 1, 1);
        reset_n = 1'b1;
        wait_runs("post_reset_run");

        check("queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
